// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and entry layouts for the instruction-fetch stage.
// The optional FETCH_PERF_CNT_EN counters live in if_fetch.sv.
package if_fetch_pkg;

  localparam int ADDR_W        = 32;
  localparam int INSTR_W       = 32;
  localparam int INSTR_BYTES   = 4;
  localparam int FETCH_EPOCH_W = 1;

  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  // One buffered instruction as presented to decode.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Carried for every granted request until its response returns.
  typedef struct packed {
    logic [ADDR_W-1:0]        pc;
    logic [FETCH_EPOCH_W-1:0] epoch;
  } tag_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head word is readable combinationally.
// Any DEPTH >= 1 is supported (pointers wrap explicitly).
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is not reset; a cleared FIFO never exposes a stale slot because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: registers use non-blocking assignment so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: in-order imem requests, epoch-tagged responses, registered decode output.
// Define FETCH_PERF_CNT_EN to add the o_fetch_cnt / o_discard_cnt counters.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC        = '0,
  parameter int                FIFO_DEPTH      = 2,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               stall,
  input  logic               i_redirect_en,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_discard_cnt
`endif
);

  localparam int DCW = $clog2(FIFO_DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [FETCH_EPOCH_W-1:0] epoch_q, epoch_d;
  logic [ADDR_W-1:0]        out_pc_q, out_pc_d;
  logic [INSTR_W-1:0]       out_instr_q, out_instr_d;
  logic                     out_valid_q, out_valid_d;

  tag_entry_t   tag_wdata, tag_rdata;
  fetch_entry_t data_wdata, data_rdata;
  logic         tag_full, tag_empty, data_full, data_empty;
  logic [TCW-1:0] tag_count;
  logic [DCW-1:0] data_count;
  logic [31:0]    in_use;
  logic           fire, rsp_take, rsp_keep, pop_out;

  // Space is reserved for every in-flight request, so a response can always be buffered.
  assign in_use     = 32'(tag_count) + 32'(data_count);
  assign o_imem_req = !clr && !i_redirect_en && (in_use < 32'(FIFO_DEPTH)) && !tag_full;
  assign o_imem_addr = pc_q;
  assign fire       = o_imem_req && i_imem_gnt;

  assign rsp_take = i_imem_rvalid && !tag_empty;
  assign rsp_keep = rsp_take && (tag_rdata.epoch == epoch_q) && !i_redirect_en;
  assign pop_out  = !i_redirect_en && !stall && !data_empty;

  assign tag_wdata  = '{pc: pc_q, epoch: epoch_q};
  assign data_wdata = '{pc: tag_rdata.pc, instr: i_imem_rdata};

  fetch_fifo #(.WIDTH($bits(tag_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .flush (clr),
    .push  (fire),
    .pop   (rsp_take),
    .wdata (tag_wdata),
    .rdata (tag_rdata),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk   (clk),
    .flush (clr || i_redirect_en),
    .push  (rsp_keep && !data_full),
    .pop   (pop_out),
    .wdata (data_wdata),
    .rdata (data_rdata),
    .full  (data_full),
    .empty (data_empty),
    .count (data_count)
  );

  // NOTE: every _d starts from its hold value so no path through this block infers a latch.
  always_comb begin
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    if (i_redirect_en) begin
      pc_d        = align_pc(i_redirect_pc);
      epoch_d     = epoch_q + FETCH_EPOCH_W'(1);
      out_pc_d    = '0;
      out_instr_d = INSTR_NOP;
      out_valid_d = 1'b0;
    end else begin
      if (fire) pc_d = pc_q + ADDR_W'(INSTR_BYTES);
      if (!stall) begin
        out_pc_d    = data_empty ? '0        : data_rdata.pc;
        out_instr_d = data_empty ? INSTR_NOP : data_rdata.instr;
        out_valid_d = !data_empty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q        <= RESET_PC;
      epoch_q     <= '0;
      out_pc_q    <= '0;
      out_instr_q <= INSTR_NOP;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_pc    = out_pc_q;
  assign o_instr = out_instr_q;
  assign o_valid = out_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, discard_cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      if (pop_out)               fetch_cnt_q   <= fetch_cnt_q + 32'd1;
      if (rsp_take && !rsp_keep) discard_cnt_q <= discard_cnt_q + 32'd1;
    end
  end

  assign o_fetch_cnt   = fetch_cnt_q;
  assign o_discard_cnt = discard_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: in-order memory model plus an expected-PC scoreboard.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [ADDR_W-1:0] RESET_PC        = '0;
  localparam int                FIFO_DEPTH      = 2;
  localparam int                MAX_OUTSTANDING = 2;

  logic               clk = 1'b0;
  logic               clr, stall, i_redirect_en;
  logic [ADDR_W-1:0]  i_redirect_pc;
  logic               o_imem_req;
  logic [ADDR_W-1:0]  o_imem_addr;
  logic               i_imem_gnt, i_imem_rvalid;
  logic [INSTR_W-1:0] i_imem_rdata;
  logic [ADDR_W-1:0]  o_pc;
  logic [INSTR_W-1:0] o_instr;
  logic               o_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        o_fetch_cnt, o_discard_cnt;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int exp_fetch = 0;
  bit mem_hold = 1'b0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] pend_q[$];
  logic [ADDR_W-1:0] hold_addr;

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .stall         (stall),
    .i_redirect_en (i_redirect_en),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_valid       (o_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt   (o_fetch_cnt),
    .o_discard_cnt (o_discard_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request before the edge, score the output after it,
  // then drive the in-order memory response for the new cycle.
  task automatic cycle();
    logic              fire, e_stall, e_redir, e_clr, h_valid;
    logic [ADDR_W-1:0] faddr, h_pc, a;
    logic [INSTR_W-1:0] h_instr;
    #2;
    fire    = o_imem_req && i_imem_gnt;
    faddr   = o_imem_addr;
    e_stall = stall;
    e_redir = i_redirect_en;
    e_clr   = clr;
    h_pc    = o_pc;
    h_instr = o_instr;
    h_valid = o_valid;
    @(posedge clk);
    #1;
    if (e_clr || e_redir) exp_q.delete();
    if (e_clr) exp_fetch = 0;
    if (fire) begin
      exp_q.push_back(faddr);
      pend_q.push_back(faddr);
    end
    if (e_clr || e_redir) begin
      check("flush_valid", o_valid, 0);
      check("flush_pc", o_pc, 0);
      check("flush_instr", o_instr, 0);
    end else if (e_stall) begin
      check("hold_valid", o_valid, h_valid);
      check("hold_pc", o_pc, h_pc);
      check("hold_instr", o_instr, h_instr);
    end else if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", o_valid, 0);
      end else begin
        a = exp_q.pop_front();
        exp_fetch++;
        check("sb_pc", o_pc, a);
        check("sb_instr", o_instr, INSTR_W'(a >> 2));
      end
    end else begin
      check("bubble_pc", o_pc, 0);
      check("bubble_instr", o_instr, 0);
    end
    if (!mem_hold && pend_q.size() != 0) begin
      a = pend_q.pop_front();
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = INSTR_W'(a >> 2);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !o_valid; i++) cycle();
    check(tag, o_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; stall = 1'b0; i_redirect_en = 1'b0; i_redirect_pc = '0;
    i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_pc", o_pc, 0);
    check("rst_instr", o_instr, 0);
    check("rst_req", o_imem_req, 0);
    check("rst_addr", o_imem_addr, RESET_PC);
    cycle();
    clr = 1'b0;

    // Streaming with a grant every cycle.
    check("s1_addr0", o_imem_addr, 32'h0);
    cycle();
    check("s1_addr4", o_imem_addr, 32'h4);
    cycle();
    check("s1_addr8", o_imem_addr, 32'h8);
    wait_valid("s1_first_valid", 10);
    check("s1_first_pc", o_pc, RESET_PC);
    check("s1_first_instr", o_instr, 0);
    repeat (12) cycle();

    // Decode stall: outputs held, buffering bounded, requests stop.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s2_inflight_bound", exp_q.size() <= FIFO_DEPTH, 1);
    end
    #1;
    check("s2_req_low", o_imem_req, 0);
    stall = 1'b0;
    repeat (10) cycle();

    // Redirect with two responses held in flight.
    mem_hold = 1'b1;
    for (int i = 0; i < 20 && pend_q.size() < 2; i++) cycle();
    check("s3_two_inflight", pend_q.size(), 2);
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'h103;
    cycle();
    i_redirect_en = 1'b0;
    mem_hold = 1'b0;
    check("s3_target_addr", o_imem_addr, 32'h100);
    wait_valid("s3_valid", 20);
    check("s3_first_pc", o_pc, 32'h100);
    check("s3_first_instr", o_instr, 32'h40);
`ifdef FETCH_PERF_CNT_EN
    check("s3_discard_cnt", o_discard_cnt, 2);
`endif
    repeat (6) cycle();

    // Redirect while stalled with a full buffer.
    stall = 1'b1;
    repeat (4) cycle();
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'h200;
    cycle();
    i_redirect_en = 1'b0;
    check("s4_valid", o_valid, 0);
    check("s4_instr", o_instr, 0);
    #1;
    check("s4_addr", o_imem_addr, 32'h200);
    check("s4_req", o_imem_req, 1);
    cycle();
    stall = 1'b0;
    wait_valid("s4_resume_valid", 20);
    check("s4_pc", o_pc, 32'h200);
    check("s4_instr_data", o_instr, 32'h80);
    repeat (4) cycle();

    // Mid-stream clear with one request outstanding.
    i_imem_gnt = 1'b0;
    repeat (4) cycle();
    i_imem_gnt = 1'b1;
    mem_hold = 1'b1;
    cycle();
    i_imem_gnt = 1'b0;
    check("s5_one_outstanding", pend_q.size(), 1);
    clr = 1'b1;
    mem_hold = 1'b0;
    #1;
    check("s5_req_in_clr", o_imem_req, 0);
    cycle();
    clr = 1'b0;
    i_imem_gnt = 1'b1;
    check("s5_valid", o_valid, 0);
    check("s5_pc", o_pc, 0);
    check("s5_instr", o_instr, 0);
    check("s5_addr", o_imem_addr, RESET_PC);
    wait_valid("s5_restart_valid", 20);
    check("s5_restart_pc", o_pc, RESET_PC);
    check("s5_restart_instr", o_instr, 0);
    repeat (3) cycle();

    // Grant withheld for ten cycles.
    i_imem_gnt = 1'b0;
    hold_addr = o_imem_addr;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("s6_addr_stable", o_imem_addr, hold_addr);
      if (i >= 4) check("s6_bubble_valid", o_valid, 0);
    end
    i_imem_gnt = 1'b1;
    repeat (4) cycle();

    // PC wraps past the top of the address space.
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFD;
    cycle();
    i_redirect_en = 1'b0;
    check("s7_target_addr", o_imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 10 && o_imem_addr == 32'hFFFF_FFFC; i++) cycle();
    check("s7_wrap_addr", o_imem_addr, 32'h0);
    wait_valid("s7_valid", 20);
    check("s7_pc", o_pc, 32'hFFFF_FFFC);
    check("s7_instr", o_instr, 32'h3FFF_FFFF);
    repeat (8) cycle();

`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", o_fetch_cnt, exp_fetch);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
